// File: rtl/cdb_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_pkg
// Shared constants and types for the common data bus (CDB) arbiter slice.
//   ROB_ADDR_W  : reorder-buffer index width (matches RoB_addr)
//   DATA_W      : result value width
//   FIFO_DEPTH  : default entries per source skid FIFO
//   cdb_src_e   : broadcast source encoding (SRC_ALU = 0, SRC_LSB = 1)
//   cdb_rec_t   : record layout held in each source FIFO, {robid, val}
//   cdb_cnt_w() : occupancy counter width for a FIFO of a given depth
// -----------------------------------------------------------------------------
package cdb_arbiter_pkg;

  localparam int ROB_ADDR_W = 4;
  localparam int DATA_W     = 32;
  localparam int FIFO_DEPTH = 2;

  typedef enum logic [0:0] {
    SRC_ALU = 1'b0,
    SRC_LSB = 1'b1
  } cdb_src_e;

  typedef struct packed {
    logic [ROB_ADDR_W-1:0] robid;
    logic [DATA_W-1:0]     val;
  } cdb_rec_t;

  // Count must represent 0..depth inclusive, hence one bit above the pointer.
  function automatic int cdb_cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cdb_arbiter_if.sv
// -----------------------------------------------------------------------------
// cdb_arbiter_if
// Producer handshakes and the broadcast bus of the CDB arbiter.
//   alu_valid/alu_robid/alu_val, alu_ready : ALU result producer handshake
//   lsb_valid/lsb_robid/lsb_val, lsb_ready : LSB result producer handshake
//   cdb_valid/cdb_src/cdb_robid/cdb_val    : registered broadcast bus
// Modports:
//   master : producer / consumer side (drives results, observes bus)
//   slave  : the arbiter (accepts results, drives ready and the bus)
// -----------------------------------------------------------------------------
interface cdb_arbiter_if #(
  parameter int ROB_ADDR_W = cdb_arbiter_pkg::ROB_ADDR_W,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_W
);
  import cdb_arbiter_pkg::*;

  logic                  alu_valid;
  logic [ROB_ADDR_W-1:0] alu_robid;
  logic [DATA_W-1:0]     alu_val;
  logic                  alu_ready;

  logic                  lsb_valid;
  logic [ROB_ADDR_W-1:0] lsb_robid;
  logic [DATA_W-1:0]     lsb_val;
  logic                  lsb_ready;

  logic                  cdb_valid;
  logic                  cdb_src;
  logic [ROB_ADDR_W-1:0] cdb_robid;
  logic [DATA_W-1:0]     cdb_val;

  modport master (
    output alu_valid, alu_robid, alu_val,
    input  alu_ready,
    output lsb_valid, lsb_robid, lsb_val,
    input  lsb_ready,
    input  cdb_valid, cdb_src, cdb_robid, cdb_val
  );

  modport slave (
    input  alu_valid, alu_robid, alu_val,
    output alu_ready,
    input  lsb_valid, lsb_robid, lsb_val,
    output lsb_ready,
    output cdb_valid, cdb_src, cdb_robid, cdb_val
  );

endinterface

// File: rtl/cdb_src_fifo.sv
// -----------------------------------------------------------------------------
// cdb_src_fifo
// Small skid FIFO holding pending results of one CDB source.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-low reset (empties the FIFO)
//   rdy_in  : global enable, low freezes pointers, count and storage
//   flush   : empties the FIFO at the next enabled edge (wins over push/pop)
//   push    : write wdata at the tail (ignored when full)
//   pop     : advance the head (ignored when empty)
//   wdata   : record to write
//   rdata   : record at the head
//   full    : count == DEPTH
//   empty   : count == 0
//   count   : current occupancy
// DEPTH must be a power of two and at least 2 so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module cdb_src_fifo #(
  parameter int WIDTH = 36,
  parameter int DEPTH = 2
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  import cdb_arbiter_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = cdb_cnt_w(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full   = (count_r == CNT_W'(DEPTH));
  assign empty  = (count_r == {CNT_W{1'b0}});
  assign count  = count_r;
  assign rdata  = mem_r[rd_ptr_r];
  assign push_s = push && !full;
  assign pop_s  = pop && !empty;

  // Pointer and occupancy bookkeeping; a simultaneous push and pop keeps the count.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else if (rdy_in) begin
      if (flush) begin
        wr_ptr_r <= {PTR_W{1'b0}};
        rd_ptr_r <= {PTR_W{1'b0}};
        count_r  <= {CNT_W{1'b0}};
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_W'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + PTR_W'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CNT_W'(1);
          2'b01:   count_r <= count_r - CNT_W'(1);
          default: count_r <= count_r;
        endcase
      end
    end
  end

  // Record storage; contents are only meaningful between head and tail, so no reset.
  always_ff @(posedge clk_in) begin
    if (rst_in && rdy_in && !flush && push_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

endmodule

// File: rtl/cdb_arbiter.sv
// -----------------------------------------------------------------------------
// cdb_arbiter
// Shares the single result broadcast bus (CDB) between the ALU and the LSB.
// Each source feeds a cdb_src_fifo; a round-robin scheduler pops at most one
// head per cycle onto the registered cdb_* outputs. Under contention the
// source that did not win the last conflict is granted (strict alternation);
// after reset the ALU wins the first conflict.
// Ports:
//   clk_in  : clock
//   rst_in  : synchronous active-low reset (priority over clear and rdy_in)
//   rdy_in  : global enable, low freezes all state
//   clear   : misprediction flush, empties both FIFOs and drops same-cycle inputs
//   bus     : cdb_arbiter_if.slave, producer handshakes and the broadcast bus
//   stat_*  : (CDB_STATS_EN only) broadcast / conflict / stall counters
// Optional feature macro: CDB_STATS_EN adds the 32-bit statistics counters.
// -----------------------------------------------------------------------------
module cdb_arbiter #(
  parameter int ROB_ADDR_W = cdb_arbiter_pkg::ROB_ADDR_W,
  parameter int DATA_W     = cdb_arbiter_pkg::DATA_W,
  parameter int FIFO_DEPTH = cdb_arbiter_pkg::FIFO_DEPTH
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clear,
  cdb_arbiter_if.slave bus
`ifdef CDB_STATS_EN
  ,
  output logic [31:0] stat_bcast,
  output logic [31:0] stat_conflict,
  output logic [31:0] stat_stall
`endif
);
  import cdb_arbiter_pkg::*;

  localparam int REC_W = ROB_ADDR_W + DATA_W;
  localparam int CNT_W = cdb_cnt_w(FIFO_DEPTH);

  logic [REC_W-1:0]      alu_head_s;
  logic [REC_W-1:0]      lsb_head_s;
  logic [CNT_W-1:0]      alu_count_s;
  logic [CNT_W-1:0]      lsb_count_s;
  logic                  alu_full_s;
  logic                  lsb_full_s;
  logic                  alu_empty_s;
  logic                  lsb_empty_s;
  logic                  alu_ready_s;
  logic                  lsb_ready_s;
  logic                  alu_push_s;
  logic                  lsb_push_s;
  logic                  alu_pop_s;
  logic                  lsb_pop_s;

  logic                  grant_valid_s;
  cdb_src_e              grant_src_s;
  logic                  conflict_s;
  logic                  take_s;
  logic [REC_W-1:0]      grant_rec_s;

  cdb_src_e              last_grant_r;
  logic                  cdb_valid_r;
  cdb_src_e              cdb_src_r;
  logic [ROB_ADDR_W-1:0] cdb_robid_r;
  logic [DATA_W-1:0]     cdb_val_r;

  // Ready reflects occupancy only: it does not credit a same-cycle pop and
  // ignores clear.
  assign alu_ready_s = (alu_count_s != CNT_W'(FIFO_DEPTH));
  assign lsb_ready_s = (lsb_count_s != CNT_W'(FIFO_DEPTH));
  assign bus.alu_ready = alu_ready_s;
  assign bus.lsb_ready = lsb_ready_s;

  assign alu_push_s = bus.alu_valid && !alu_full_s && !clear;
  assign lsb_push_s = bus.lsb_valid && !lsb_full_s && !clear;

  // A grant is only consumed on an enabled, non-flushing edge.
  assign take_s    = rdy_in && !clear && grant_valid_s;
  assign alu_pop_s = take_s && (grant_src_s == SRC_ALU);
  assign lsb_pop_s = take_s && (grant_src_s == SRC_LSB);

  cdb_src_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_alu_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (clear),
    .push   (alu_push_s),
    .pop    (alu_pop_s),
    .wdata  ({bus.alu_robid, bus.alu_val}),
    .rdata  (alu_head_s),
    .full   (alu_full_s),
    .empty  (alu_empty_s),
    .count  (alu_count_s)
  );

  cdb_src_fifo #(
    .WIDTH (REC_W),
    .DEPTH (FIFO_DEPTH)
  ) u_lsb_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .rdy_in (rdy_in),
    .flush  (clear),
    .push   (lsb_push_s),
    .pop    (lsb_pop_s),
    .wdata  ({bus.lsb_robid, bus.lsb_val}),
    .rdata  (lsb_head_s),
    .full   (lsb_full_s),
    .empty  (lsb_empty_s),
    .count  (lsb_count_s)
  );

  // Round-robin grant on pre-enqueue FIFO state.
  always_comb begin
    grant_valid_s = 1'b0;
    grant_src_s   = SRC_ALU;
    conflict_s    = 1'b0;
    case ({!alu_empty_s, !lsb_empty_s})
      2'b11: begin
        grant_valid_s = 1'b1;
        conflict_s    = 1'b1;
        grant_src_s   = (last_grant_r == SRC_LSB) ? SRC_ALU : SRC_LSB;
      end
      2'b10: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_ALU;
      end
      2'b01: begin
        grant_valid_s = 1'b1;
        grant_src_s   = SRC_LSB;
      end
      default: begin
        grant_valid_s = 1'b0;
        grant_src_s   = SRC_ALU;
      end
    endcase
  end

  // Head record of the granted source.
  always_comb begin
    grant_rec_s = alu_head_s;
    if (grant_src_s == SRC_LSB) begin
      grant_rec_s = lsb_head_s;
    end else begin
      grant_rec_s = alu_head_s;
    end
  end

  // Broadcast register and round-robin history; last_grant moves only on a conflict.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      cdb_valid_r  <= 1'b0;
      cdb_src_r    <= SRC_ALU;
      cdb_robid_r  <= {ROB_ADDR_W{1'b0}};
      cdb_val_r    <= {DATA_W{1'b0}};
      last_grant_r <= SRC_LSB;
    end else if (rdy_in) begin
      if (clear) begin
        cdb_valid_r <= 1'b0;
      end else if (grant_valid_s) begin
        cdb_valid_r <= 1'b1;
        cdb_src_r   <= grant_src_s;
        cdb_robid_r <= grant_rec_s[REC_W-1:DATA_W];
        cdb_val_r   <= grant_rec_s[DATA_W-1:0];
        if (conflict_s) begin
          last_grant_r <= grant_src_s;
        end
      end else begin
        cdb_valid_r <= 1'b0;
      end
    end
  end

  assign bus.cdb_valid = cdb_valid_r;
  assign bus.cdb_src   = cdb_src_r;
  assign bus.cdb_robid = cdb_robid_r;
  assign bus.cdb_val   = cdb_val_r;

`ifdef CDB_STATS_EN
  logic [31:0] stat_bcast_r;
  logic [31:0] stat_conflict_r;
  logic [31:0] stat_stall_r;
  logic [1:0]  stall_inc_s;

  assign stall_inc_s = {1'b0, (bus.alu_valid && !alu_ready_s)}
                     + {1'b0, (bus.lsb_valid && !lsb_ready_s)};

  // Statistics counters; they wrap, survive clear and only advance when enabled.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      stat_bcast_r    <= 32'd0;
      stat_conflict_r <= 32'd0;
      stat_stall_r    <= 32'd0;
    end else if (rdy_in) begin
      stat_bcast_r    <= stat_bcast_r + 32'(take_s);
      stat_conflict_r <= stat_conflict_r + 32'(conflict_s);
      stat_stall_r    <= stat_stall_r + 32'(stall_inc_s);
    end
  end

  assign stat_bcast    = stat_bcast_r;
  assign stat_conflict = stat_conflict_r;
  assign stat_stall    = stat_stall_r;
`endif

endmodule
